// File: rtl/dft1.sv
// 5-bit register/accumulate/count/mix datapath with a three-stage output pipe.
// All 30 flops are mux-D scan cells on two 15-bit chains.
module dft1 (
  input  logic       refclk,
  input  logic       reset,
  input  logic       clk2,
  input  logic       test_mode,
  input  logic       se,
  input  logic       si1,
  input  logic       si2,
  input  logic [4:0] data_in,
  output logic [4:0] data_out,
  output logic       so1,
  output logic       so2
);

  logic [4:0] in_reg_q, in_reg_d;
  logic [4:0] acc_q, acc_d;
  logic [4:0] cnt_q, cnt_d;
  logic [4:0] mix_q, mix_d;
  logic [4:0] dly_q, dly_d;
  logic [4:0] out_reg_q, out_reg_d;

  logic        shift;
  logic [14:0] chain1_q, chain2_q;
  logic [14:0] chain1_sh, chain2_sh;

  // clk2 exists only for pin compatibility and drives nothing.
  logic unused_clk2;
  assign unused_clk2 = clk2;

  assign shift = test_mode & se;

  // Bit 0 of each chain vector is the cell nearest its scan-in.
  assign chain1_q  = {cnt_q, acc_q, in_reg_q};
  assign chain2_q  = {out_reg_q, dly_q, mix_q};
  assign chain1_sh = {chain1_q[13:0], si1};
  assign chain2_sh = {chain2_q[13:0], si2};

  always_comb begin
    in_reg_d  = data_in;
    acc_d     = acc_q + in_reg_q;
    cnt_d     = cnt_q + 5'd1;
    mix_d     = acc_q ^ cnt_q;
    dly_d     = mix_q;
    out_reg_d = dly_q;
    if (shift) begin
      {cnt_d, acc_d, in_reg_d}    = chain1_sh;
      {out_reg_d, dly_d, mix_d}   = chain2_sh;
    end
  end

  always_ff @(posedge refclk) begin
    if (reset) begin
      in_reg_q  <= 5'd0;
      acc_q     <= 5'd0;
      cnt_q     <= 5'd0;
      mix_q     <= 5'd0;
      dly_q     <= 5'd0;
      out_reg_q <= 5'd0;
    end else begin
      in_reg_q  <= in_reg_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      mix_q     <= mix_d;
      dly_q     <= dly_d;
      out_reg_q <= out_reg_d;
    end
  end

  assign data_out = out_reg_q;
  assign so1      = cnt_q[4];
  assign so2      = out_reg_q[4];

endmodule

// File: tb/tb_dft1.sv
// Directed bench for dft1: reset, functional count/accumulate, scan shift and capture.
module tb_dft1;

  logic       refclk = 1'b0;
  logic       clk2 = 1'b0;
  logic       reset = 1'b1;
  logic       test_mode = 1'b0;
  logic       se = 1'b0;
  logic       si1 = 1'b0;
  logic       si2 = 1'b0;
  logic [4:0] data_in = 5'd0;
  logic [4:0] data_out;
  logic       so1;
  logic       so2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0] d;
    logic       chk_d;
    logic       s1;
    logic       s2;
    string      tag;
  } exp_t;

  exp_t sb[$];

  dft1 dut (
    .refclk   (refclk),
    .reset    (reset),
    .clk2     (clk2),
    .test_mode(test_mode),
    .se       (se),
    .si1      (si1),
    .si2      (si2),
    .data_in  (data_in),
    .data_out (data_out),
    .so1      (so1),
    .so2      (so2)
  );

  always #5 refclk = ~refclk;
  always #7 clk2 = ~clk2;

  // Push the expectation for the coming edge, clock it, then pop and compare.
  task automatic cyc(input logic [4:0] exp_d, input logic chk_d, input logic e1, input logic e2,
                     input string tag);
    exp_t e;
    sb.push_back('{d: exp_d, chk_d: chk_d, s1: e1, s2: e2, tag: tag});
    @(posedge refclk);
    #1;
    e = sb.pop_front();
    if (e.chk_d) begin
      checks++;
      assert (data_out === e.d) else begin
        errors++;
        $error("FAIL %s data_out got=%b exp=%b", e.tag, data_out, e.d);
      end
    end
    checks++;
    assert (so1 === e.s1) else begin
      errors++;
      $error("FAIL %s so1 got=%b exp=%b", e.tag, so1, e.s1);
    end
    checks++;
    assert (so2 === e.s2) else begin
      errors++;
      $error("FAIL %s so2 got=%b exp=%b", e.tag, so2, e.s2);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(5'd0, 1'b1, 1'b0, 1'b0, "reset");
    reset = 1'b0;
  endtask

  initial begin
    logic [4:0]  d;
    logic [4:0]  c;
    logic [14:0] ld1, ld2, cap1, cap2;

    // Reset dominates active scan and data.
    reset = 1'b1; test_mode = 1'b1; se = 1'b1; si1 = 1'b1; si2 = 1'b1; data_in = 5'd21;
    cyc(5'd0, 1'b1, 1'b0, 1'b0, "reset_a");
    cyc(5'd0, 1'b1, 1'b0, 1'b0, "reset_b");

    // Functional count with data_in=0; se/si toggling must be ignored out of test mode.
    do_reset();
    test_mode = 1'b0; data_in = 5'd0;
    for (int k = 1; k <= 40; k++) begin
      se = k[0]; si1 = k[1]; si2 = ~k[0];
      d = (k >= 3) ? 5'(k - 3) : 5'd0;
      c = 5'(k);
      cyc(d, 1'b1, c[4], d[4], "count");
    end

    // Accumulate with data_in=1: out_k = acc_{k-3} ^ cnt_{k-3}, acc_j = j-1.
    do_reset();
    se = 1'b0; data_in = 5'd1;
    for (int k = 1; k <= 20; k++) begin
      int j;
      j = k - 3;
      d = (j <= 0) ? 5'd0 : (5'(j - 1) ^ 5'(j));
      c = 5'(k);
      cyc(d, 1'b1, c[4], d[4], "accum");
    end

    // Shift zeros through both chains.
    do_reset();
    test_mode = 1'b1; se = 1'b1; si1 = 1'b0; si2 = 1'b0; data_in = 5'd31;
    for (int k = 1; k <= 30; k++) cyc(5'd0, 1'b1, 1'b0, 1'b0, "shift0");

    // Shift ones: visible at so after exactly 15 edges.
    si1 = 1'b1; si2 = 1'b1;
    for (int k = 1; k <= 14; k++) cyc(5'd0, 1'b0, 1'b0, 1'b0, "shift1_lat");
    cyc(5'b11111, 1'b1, 1'b1, 1'b1, "shift1_full");

    // Load pattern: in=7 acc=20 cnt=31 / mix=9 dly=18 out=3, chain MSB first.
    ld1 = {5'd31, 5'd20, 5'd7};
    ld2 = {5'd3, 5'd18, 5'd9};
    for (int t = 0; t < 15; t++) begin
      si1 = ld1[14 - t];
      si2 = ld2[14 - t];
      if (t < 14) cyc(5'd0, 1'b0, 1'b1, 1'b1, "load_old");
      else        cyc(5'd3, 1'b1, ld1[14], ld2[14], "load_done");
    end

    // Capture edge: in=12, acc=20+7=27, cnt=31+1 wraps to 0, mix=20^31=11, dly=9, out=18.
    se = 1'b0; data_in = 5'd12; si1 = 1'b1; si2 = 1'b1;
    cap1 = {5'd0, 5'd27, 5'd12};
    cap2 = {5'd18, 5'd9, 5'd11};
    cyc(5'd18, 1'b1, cap1[14], cap2[14], "capture");

    // Unload the captured state, zeros shifted behind it.
    se = 1'b1; si1 = 1'b0; si2 = 1'b0;
    for (int j = 1; j <= 14; j++) cyc(5'd0, 1'b0, cap1[14 - j], cap2[14 - j], "unload");
    cyc(5'd0, 1'b1, 1'b0, 1'b0, "unload_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
